// File: rtl/iterative_shift_ctrl.sv
// iterative_shift_ctrl: multi-cycle one-bit-per-cycle shifter (SLL/SRL/SRA/ROL) with valid/ready handshakes
module iterative_shift_ctrl #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               busy_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         op;
    logic [WIDTH-1:0]   step;
    always_comb begin
        step = op == 2'b00 ? {data_o[WIDTH-2:0], 1'b0} :
               op == 2'b01 ? {1'b0, data_o[WIDTH-1:1]} :
               op == 2'b10 ? {data_o[WIDTH-1], data_o[WIDTH-1:1]} :
                             {data_o[WIDTH-2:0], data_o[WIDTH-1]};
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            data_o      <= '0;
            cnt         <= '0;
            op          <= 2'b00;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    data_o     <= data_i;
                    cnt        <= shamt_i;
                    op         <= op_i;
                    in_ready_o <= 1'b0;
                    busy_o     <= 1'b1;
                    if (shamt_i == '0) begin
                        state       <= DONE;
                        out_valid_o <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_o <= step;
                    cnt    <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        state       <= DONE;
                        out_valid_o <= 1'b1;
                    end
                end
                DONE: if (out_ready_i) begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    busy_o      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/iterative_shift_ctrl.md
Name: iterative_shift_ctrl

Overview:
Multi-cycle shift unit controller for the 64-bit datapath. It sequences a one-bit-per-cycle shift stage, the same operation as the existing shift-left-one block, extended to SRL/SRA/ROL. It produces an arbitrary-amount shift over several cycles with a valid/ready handshake on both sides. It sits beside the ALU as an area-cheap alternative to a barrel shifter for multi-cycle shift instructions.

Parameters:
WIDTH, 64, data width in bits
SHAMT_W, 6, shift-amount width; equals log2(WIDTH), so every shift amount is in range

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
in_valid_i  input  1  request valid
in_ready_o  output  1  unit can accept a request
data_i  input  WIDTH  operand
shamt_i  input  SHAMT_W  shift amount, 0..WIDTH-1
op_i  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left)
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
data_o  output  WIDTH  result
busy_o  output  1  high in SHIFT or DONE

Behaviour:
- Reset values (rst_i high at an edge): state IDLE; in_ready_o=1; out_valid_o=0; busy_o=0; data_o=0; internal counter=0; op register=00.
- States:
  - IDLE: in_ready_o=1.
  - SHIFT: shifting in progress.
  - DONE: out_valid_o=1.
- in_ready_o = (state==IDLE). busy_o = (state!=IDLE). out_valid_o = (state==DONE).
- Accept occurs on an edge where in_valid_i && in_ready_o. On accept:
  - Load data_i into the shift register, shamt_i into the counter, op_i into the op register.
  - Next state is DONE if shamt_i==0, else SHIFT.
- SHIFT, per edge: one-bit step on the shift register, counter decrements by 1. When the counter was 1 before the edge, next state is DONE.
- One-bit step by op:
  - SLL: {r[W-2:0],0}
  - SRL: {0,r[W-1:1]}
  - SRA: {r[W-1],r[W-1:1]}
  - ROL: {r[W-2:0],r[W-1]}
- Latency: for shift amount S, out_valid_o is high in the cycle after S+1 rising edges counted from and including the accept edge. S=0 gives 1 cycle; S=63 gives 64 cycles.
- data_o is driven from the shift register. It is guaranteed only while out_valid_o=1, and must then stay stable until the output handshake.
- DONE: hold data_o and out_valid_o until an edge with out_ready_i=1, then go to IDLE. No same-edge re-accept: the next request is accepted no earlier than the following edge, so throughput is at most one op per S+2 cycles.
- In SHIFT or DONE, in_valid_i, data_i, shamt_i and op_i are ignored. Changes on these inputs must not affect the in-flight result.
- out_ready_i is ignored outside DONE.
- Reset mid-operation (SHIFT or DONE): the in-flight result is discarded with no out_valid_o pulse, and all outputs return to reset values on that edge.
- Reset dominates a simultaneous accept or output handshake on the same edge.
- No combinational path from in_valid_i or out_ready_i to any output; all outputs derive from registers.

Test Plan:
- SLL, data_i=0x0000_0000_0000_0001, shamt_i=63, out_ready_i=1 -> out_valid_o high exactly 64 cycles after accept, data_o=0x8000_0000_0000_0000, then IDLE with in_ready_o=1.
- SRA, data_i=0x8000_0000_0000_0000, shamt_i=4 -> data_o=0xF800_0000_0000_0000. Same with SRL -> 0x0800_0000_0000_0000.
- ROL, data_i=0x8000_0000_0000_0001, shamt_i=1 -> data_o=0x0000_0000_0000_0003; shamt_i=0 -> data_o=0x8000_0000_0000_0001 with out_valid_o one cycle after accept.
- Backpressure: SLL 0xFF by 8 with out_ready_i=0 for 5 cycles in DONE -> data_o=0xFF00 stable, out_valid_o=1, in_ready_o=0, and a new in_valid_i is not accepted. Raise out_ready_i -> IDLE on the next edge.
- Input disturbance: change data_i/shamt_i/op_i every cycle during SHIFT -> result matches the operands captured at accept.
- Reset mid-shift: assert rst_i during SHIFT of shamt 40 at cycle 10 -> next cycle state IDLE, out_valid_o=0, data_o=0, in_ready_o=1, no spurious out_valid_o. A fresh request then completes correctly.
